// File: rtl/maluca_pkg.sv
// Shared controller state encoding and datapath widths for controlador_maluca.
package maluca_pkg;

  typedef enum logic [2:0] {
    C_IDLE  = 3'd0,
    C_START = 3'd1,
    C_LEAVE = 3'd2,
    C_RUN   = 3'd3,
    C_DONE  = 3'd4
  } ctrl_state_t;

  localparam int RUNS_W = 8;
  localparam int LEN_W  = 8;
  localparam int WAIT_W = 16;

  function automatic logic [RUNS_W-1:0] sat_inc_runs(input logic [RUNS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/controlador_maluca_contador_sat.sv
// Saturating up-counter with synchronous load; holds at all-ones instead of wrapping.
module contador_sat
  import maluca_pkg::*;
#(
  parameter int WIDTH = LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] init_val,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load has priority over increment; increment stops at the maximum value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = init_val;
    end else if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/controlador_maluca.sv
// Run sequencer: issues start pulses to an external machine, watches its state code,
// times each run and flags a timeout when the machine fails to leave or return to idle.
//
// state   | meaning
// C_IDLE  | waiting for a command, cmd_ready high
// C_START | one-cycle start pulse, wait counter cleared
// C_LEAVE | waiting for the machine to leave IDLE_CODE
// C_RUN   | waiting for the machine to return to IDLE_CODE
// C_DONE  | one-cycle done pulse
module controlador_maluca
  import maluca_pkg::*;
#(
  parameter logic [3:0] IDLE_CODE = 4'd1,
  parameter int         TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_runs,
  output logic       cmd_ready,
  output logic       start,
  input  logic [3:0] state,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] runs_done,
  output logic [7:0] last_len
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  ctrl_state_t       st_q, st_d;
  logic [RUNS_W-1:0] runs_lat_q, runs_lat_d;
  logic [RUNS_W-1:0] runs_done_q, runs_done_d;
  logic [LEN_W-1:0]  last_len_q, last_len_d;
  logic              error_q, error_d;

  logic              wait_clr, wait_inc;
  logic [WAIT_W-1:0] wait_cnt;
  logic              len_clr, len_inc;
  logic [LEN_W-1:0]  len_cnt;

  logic              idle_seen;
  logic              more_runs;

  assign idle_seen = (state == IDLE_CODE);
  assign more_runs = ({1'b0, runs_done_q} + 9'd1) < {1'b0, runs_lat_q};

  contador_sat #(.WIDTH(WAIT_W)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .clr      (wait_clr),
    .init_val ('0),
    .inc      (wait_inc),
    .cnt      (wait_cnt)
  );

  // Run length is 1 in the start cycle, so the loaded value is one rather than zero.
  contador_sat #(.WIDTH(LEN_W)) u_len (
    .clk      (clk),
    .rst      (rst),
    .clr      (len_clr),
    .init_val (LEN_W'(1)),
    .inc      (len_inc),
    .cnt      (len_cnt)
  );

  // Next-state, counter control and result register updates.
  always_comb begin
    st_d        = st_q;
    runs_lat_d  = runs_lat_q;
    runs_done_d = runs_done_q;
    last_len_d  = last_len_q;
    error_d     = error_q;
    wait_clr    = 1'b0;
    wait_inc    = 1'b0;
    len_clr     = 1'b0;
    len_inc     = 1'b0;
    unique case (st_q)
      C_IDLE: begin
        if (cmd_valid) begin
          runs_lat_d  = cmd_runs;
          runs_done_d = '0;
          error_d     = 1'b0;
          if (cmd_runs == '0) begin
            st_d = C_DONE;
          end else begin
            st_d    = C_START;
            len_clr = 1'b1;
          end
        end
      end
      C_START: begin
        wait_clr = 1'b1;
        len_inc  = 1'b1;
        st_d     = C_LEAVE;
      end
      C_LEAVE: begin
        len_inc = 1'b1;
        if (!idle_seen) begin
          wait_clr = 1'b1;
          st_d     = C_RUN;
        end else if (wait_cnt == WAIT_LAST) begin
          error_d = 1'b1;
          st_d    = C_DONE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      C_RUN: begin
        if (idle_seen) begin
          runs_done_d = sat_inc_runs(runs_done_q);
          last_len_d  = len_cnt;
          wait_clr    = 1'b1;
          if (more_runs) begin
            st_d    = C_START;
            len_clr = 1'b1;
          end else begin
            st_d = C_DONE;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          error_d = 1'b1;
          st_d    = C_DONE;
        end else begin
          wait_inc = 1'b1;
          len_inc  = 1'b1;
        end
      end
      C_DONE: begin
        st_d = C_IDLE;
      end
      default: begin
        st_d = C_IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= C_IDLE;
      runs_lat_q  <= '0;
      runs_done_q <= '0;
      last_len_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      st_q        <= st_d;
      runs_lat_q  <= runs_lat_d;
      runs_done_q <= runs_done_d;
      last_len_q  <= last_len_d;
      error_q     <= error_d;
    end
  end

  assign cmd_ready = (st_q == C_IDLE);
  assign busy      = (st_q != C_IDLE);
  assign start     = (st_q == C_START);
  assign done      = (st_q == C_DONE);
  assign error     = error_q;
  assign runs_done = runs_done_q;
  assign last_len  = last_len_q;

endmodule

// File: tb/tb_controlador_maluca.sv
// Directed bench for controlador_maluca with a behavioural model of the controlled machine.
module tb_controlador_maluca;

  localparam logic [3:0] IDLE_C = 4'd1;
  localparam int         TMO    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_runs = 8'd0;
  logic [3:0] state;
  logic       cmd_ready, start, busy, done, error;
  logic [7:0] runs_done, last_len;

  always #5 clk = ~clk;

  controlador_maluca #(.IDLE_CODE(IDLE_C), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_runs  (cmd_runs),
    .cmd_ready (cmd_ready),
    .start     (start),
    .state     (state),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .runs_done (runs_done),
    .last_len  (last_len)
  );

  // Machine model. mode 0: busy 1 cycle after start for 5 cycles; 1: stuck idle; 2: hangs at 5.
  int         mode = 0;
  logic [3:0] left;
  logic       hang_armed;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      left       <= 4'd0;
      hang_armed <= 1'b0;
    end else begin
      if (start)            left <= 4'd5;
      else if (left != 0)   left <= left - 4'd1;
      hang_armed <= (mode == 2) && (hang_armed || start);
    end
  end

  always_comb begin
    state = IDLE_C;
    if (mode == 2)      state = hang_armed ? 4'd5 : IDLE_C;
    else if (mode == 0) state = (left != 0) ? 4'd3 : IDLE_C;
  end

  typedef struct {
    logic [7:0] runs;
    logic       err;
    logic [7:0] len;
    int         starts;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one command, follow it to its done pulse, then score the result.
  task automatic run_cmd(input string tag, input logic [7:0] n, input logic exp_err,
                         input logic [7:0] exp_runs, input logic [7:0] exp_len,
                         input int exp_starts, input int exp_lat, input logic noise);
    exp_t e;
    int   cyc;
    int   starts;
    logic got;
    logic busy_ok;
    e.runs = exp_runs; e.err = exp_err; e.len = exp_len;
    e.starts = exp_starts; e.lat = exp_lat;
    sb.push_back(e);
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_runs  = n;
    @(negedge clk);
    cmd_valid = noise;
    cmd_runs  = 8'd0;
    chk({tag, "_err_clr"}, 32'(error), 32'd0);
    starts  = 0;
    got     = 1'b0;
    busy_ok = 1'b1;
    for (cyc = 1; cyc <= 3000; cyc++) begin
      if (!busy || cmd_ready) busy_ok = 1'b0;
      if (start) starts++;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    e = sb.pop_front();
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    chk({tag, "_starts"}, 32'(starts), 32'(e.starts));
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
    chk({tag, "_runs_done"}, 32'(runs_done), 32'(e.runs));
    chk({tag, "_error"}, 32'(error), 32'(e.err));
    chk({tag, "_last_len"}, 32'(last_len), 32'(e.len));
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_runs", 32'(runs_done), 32'd0);
    chk("rst_len", 32'(last_len), 32'd0);
    rst = 1'b0;

    mode = 0;
    run_cmd("single", 8'd1, 1'b0, 8'd1, 8'd7, 1, 8, 1'b0);
    run_cmd("multi", 8'd3, 1'b0, 8'd3, 8'd7, 3, 22, 1'b1);
    run_cmd("zero", 8'd0, 1'b0, 8'd0, 8'd7, 0, 1, 1'b0);
    mode = 1;
    run_cmd("stuck", 8'd2, 1'b1, 8'd0, 8'd7, 1, 10, 1'b0);
    mode = 2;
    run_cmd("hang", 8'd1, 1'b1, 8'd0, 8'd7, 1, 11, 1'b0);
    chk("hang_err_sticky", 32'(error), 32'd1);
    mode = 0;
    run_cmd("recover", 8'd1, 1'b0, 8'd1, 8'd7, 1, 8, 1'b0);
    run_cmd("b2b", 8'd2, 1'b0, 8'd2, 8'd7, 2, 15, 1'b0);
    run_cmd("max", 8'd255, 1'b0, 8'd255, 8'd7, 255, 1786, 1'b0);

    // Asynchronous reset in the middle of the first run of a 3-run command.
    cmd_valid = 1'b1;
    cmd_runs  = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_start", 32'(start), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_error", 32'(error), 32'd0);
    chk("arst_runs", 32'(runs_done), 32'd0);
    chk("arst_len", 32'(last_len), 32'd0);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("arst_no_done", 32'(dones), 32'd0);
    rst = 1'b0;
    run_cmd("resume", 8'd1, 1'b0, 8'd1, 8'd7, 1, 8, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
